// File: rtl/hazard_unit.sv
// Hazard control for a 5-stage MIPS pipeline: stall/flush/forward selects, shadow regwrite/memtoreg pipeline, stall watchdog.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       regwriteD,
  input  logic       memtoregD,
  input  logic       branchD,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       hazard_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] branch_stalls,
  output logic [CNT_W-1:0] fwd_events
`endif
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_ERR = RUN_W'(MAX_STALL);

  logic regwrite_e_q, memtoreg_e_q, regwrite_m_q, memtoreg_m_q, regwrite_w_q;
  logic [RUN_W-1:0] stall_run_q, stall_run_d;
  logic hazard_err_q, hazard_err_d;

  logic lwstall, branchstall, stall;
  logic fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

  // r0 is hardwired to zero, so it never creates a dependency.
  function automatic logic tag_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  always_comb begin
    lwstall = memtoreg_e_q && (tag_match(rsD, rtE) || tag_match(rtD, rtE));
    branchstall = branchD &&
                  ((regwrite_e_q && (tag_match(rsD, writeregE) || tag_match(rtD, writeregE))) ||
                   (memtoreg_m_q && (tag_match(rsD, writeregM) || tag_match(rtD, writeregM))));
    stall = (lwstall || branchstall) && !reset;

    fwd_ad = !reset && regwrite_m_q && tag_match(rsD, writeregM);
    fwd_bd = !reset && regwrite_m_q && tag_match(rtD, writeregM);

    fwd_ae = 2'b00;
    if (reset)                                       fwd_ae = 2'b00;
    else if (regwrite_m_q && tag_match(rsE, writeregM)) fwd_ae = 2'b10;
    else if (regwrite_w_q && tag_match(rsE, writeregW)) fwd_ae = 2'b01;

    fwd_be = 2'b00;
    if (reset)                                       fwd_be = 2'b00;
    else if (regwrite_m_q && tag_match(rtE, writeregM)) fwd_be = 2'b10;
    else if (regwrite_w_q && tag_match(rtE, writeregW)) fwd_be = 2'b01;
  end

  assign stallF     = stall;
  assign stallD     = stall;
  assign flushE     = stall;
  assign forwardAD  = fwd_ad;
  assign forwardBD  = fwd_bd;
  assign forwardAE  = fwd_ae;
  assign forwardBE  = fwd_be;
  assign hazard_err = hazard_err_q;

  always_comb begin
    stall_run_d = '0;
    if (stall) begin
      stall_run_d = (stall_run_q == RUN_SAT) ? stall_run_q : stall_run_q + 1'b1;
    end
    hazard_err_d = hazard_err_q || (stall_run_d >= RUN_ERR);
  end

  // E/M/W shadows advance every cycle; a flush inserts a bubble in E only.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      regwrite_w_q <= 1'b0;
      stall_run_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      regwrite_e_q <= stall ? 1'b0 : regwriteD;
      memtoreg_e_q <= stall ? 1'b0 : memtoregD;
      regwrite_m_q <= regwrite_e_q;
      memtoreg_m_q <= memtoreg_e_q;
      regwrite_w_q <= regwrite_m_q;
      stall_run_q  <= stall_run_d;
      hazard_err_q <= hazard_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, branch_stalls_q, fwd_events_q;
  logic fwd_any;

  assign fwd_any = fwd_ad || fwd_bd || (fwd_ae != 2'b00) || (fwd_be != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= '0;
      branch_stalls_q <= '0;
      fwd_events_q    <= '0;
    end else begin
      if (stall && !(&stall_cycles_q))          stall_cycles_q  <= stall_cycles_q + 1'b1;
      if (branchstall && !(&branch_stalls_q))   branch_stalls_q <= branch_stalls_q + 1'b1;
      if (fwd_any && !(&fwd_events_q))          fwd_events_q    <= fwd_events_q + 1'b1;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign branch_stalls = branch_stalls_q;
  assign fwd_events    = fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset, regwriteD, memtoregD, branchD;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic stallF, stallD, flushE, forwardAD, forwardBD, hazard_err;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, branch_stalls, fwd_events;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.MAX_STALL(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .regwriteD(regwriteD), .memtoregD(memtoregD), .branchD(branchD),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .hazard_err(hazard_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .branch_stalls(branch_stalls), .fwd_events(fwd_events)
`endif
  );

  typedef struct {
    string      name;
    logic [9:0] exp;
    int         exp_sc;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // {stallF, stallD, flushE, fAD, fBD, fAE, fBE, err}
  function automatic logic [9:0] mk(input logic st, input logic fad, input logic fbd,
                                    input logic [1:0] fae, input logic [1:0] fbe, input logic err);
    return {st, st, st, fad, fbd, fae, fbe, err};
  endfunction

  task automatic vec(input string name, input logic chk, input logic rst,
                     input logic rw, input logic mtr, input logic br,
                     input logic [4:0] rs_d, input logic [4:0] rt_d,
                     input logic [4:0] rs_e, input logic [4:0] rt_e,
                     input logic [4:0] w_e, input logic [4:0] w_m, input logic [4:0] w_w,
                     input logic [9:0] exp, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; regwriteD = rw; memtoregD = mtr; branchD = br;
    rsD = rs_d; rtD = rt_d; rsE = rs_e; rtE = rt_e;
    writeregE = w_e; writeregM = w_m; writeregW = w_w;
    if (chk) begin
      e.name = name; e.exp = exp; e.exp_sc = sc;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [9:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, hazard_err};
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: outputs got %b expected %b", e.name, act, e.exp);
      end else begin
        $display("vec %s: outputs %b ok", e.name, act);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.exp_sc >= 0) begin
        n_vec++;
        if (stall_cycles !== 16'(e.exp_sc)) begin
          n_bad++;
          $display("FAIL %s_stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.exp_sc);
        end
      end
`endif
    end
  end

  initial begin
    reset = 1'b1; regwriteD = 1'b0; memtoregD = 1'b0; branchD = 1'b0;
    rsD = '0; rtD = '0; rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;

    //   name          chk rst rw mtr br rsD rtD rsE rtE wE wM wW  expected                        sc
    vec("reset0",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("reset1",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), 0);
    vec("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("wr_in_D",     1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("wr_in_E",     1, 0, 0, 0, 0, 8, 0, 0, 0, 8, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("fwdAE_M",     1, 0, 0, 0, 0, 0, 0, 8, 0, 0, 8, 0, mk(0,0,0,2'b10,2'b00,0), -1);
    vec("fwdAE_W",     1, 0, 0, 0, 0, 0, 0, 8, 0, 0, 3, 8, mk(0,0,0,2'b01,2'b00,0), -1);
    vec("idle2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("load_in_D",   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("lwstall",     1, 0, 0, 0, 0, 9, 0, 0, 9, 0, 0, 0, mk(1,0,0,2'b00,2'b00,0), -1);
    vec("lw_bubble",   1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 9, 0, mk(0,1,0,2'b00,2'b00,0), -1);
    vec("idle3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("load_in_D2",  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("br_stall_E",  1, 0, 0, 0, 1, 5, 0, 0, 5, 5, 0, 0, mk(1,0,0,2'b00,2'b00,0), -1);
    vec("br_stall_M",  1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 5, 0, mk(1,1,0,2'b00,2'b00,0), -1);
    vec("br_go_W",     1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 5, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("br_no_err",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("load_in_D3",  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("r0_lw",       1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("r0_fwd_br",   1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);
    vec("M_over_W",    1, 0, 0, 0, 0, 0, 7, 7, 7, 0, 7, 7, mk(0,0,1,2'b10,2'b10,0), -1);
    vec("fwdBE_W",     1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 4, 6, mk(0,0,0,2'b00,2'b01,0), -1);
    vec("idle4",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,0), -1);

    // A legal program cannot stall more than twice in a row, so a stuck E-stage write is emulated.
    @(negedge clk);
    force dut.regwrite_e_q = 1'b1;
    vec("wd_stall1",   1, 0, 0, 0, 1, 5, 0, 0, 0, 5, 0, 0, mk(1,0,0,2'b00,2'b00,0), -1);
    vec("wd_stall2",   1, 0, 0, 0, 1, 5, 0, 0, 0, 5, 0, 0, mk(1,0,0,2'b00,2'b00,0), -1);
    vec("wd_stall3",   1, 0, 0, 0, 1, 5, 0, 0, 0, 5, 0, 0, mk(1,0,0,2'b00,2'b00,0), -1);
    vec("wd_err_set",  1, 0, 0, 0, 1, 5, 0, 0, 0, 5, 0, 0, mk(1,0,0,2'b00,2'b00,1), -1);
    release dut.regwrite_e_q;
    vec("wd_sticky",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,2'b00,2'b00,1), 7);
    vec("rst_force0",  1, 1, 0, 0, 1, 5, 0, 5, 0, 5, 5, 0, mk(0,0,0,2'b00,2'b00,1), -1);
    vec("post_reset",  1, 0, 0, 0, 1, 5, 0, 5, 0, 5, 5, 0, mk(0,0,0,2'b00,2'b00,0), 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
